mem_rd_arbiter: RTL and testbench



---
 rtl/mem_rd_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_rd_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: shares one burst memory read channel between the I-cache
// and D-cache miss paths. Grants one line read at a time with round-robin
// fairness, holds the channel for the whole burst, steers response beats to
// the owning cache and raises a sticky flag on malformed burst lengths.
module mem_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ic_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_rd_req_addr,
    output logic                  ic_rd_req_ready,
    output logic                  ic_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] ic_rd_rsp_data,
    output logic                  ic_rd_rsp_last,
    input  logic                  ic_rd_rsp_ready,

    input  logic                  dc_rd_req_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_req_addr,
    output logic                  dc_rd_req_ready,
    output logic                  dc_rd_rsp_valid,
    output logic [DATA_WIDTH-1:0] dc_rd_rsp_data,
    output logic                  dc_rd_rsp_last,
    input  logic                  dc_rd_rsp_ready,

    output logic                  mem_rd_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
    input  logic                  mem_rd_req_ready,
    input  logic                  mem_rd_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_rsp_data,
    input  logic                  mem_rd_rsp_last,
    output logic                  mem_rd_rsp_ready,

    output logic                  owner,
    output logic                  busy,
    output logic                  beat_err
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        REQ  = 3'b010,
        RSP  = 3'b100
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         beat_cnt;

    logic in_req;
    logic in_rsp;
    logic grant_dc;
    logic rsp_hs;
    logic cnt_at_last;

    assign in_req      = (state == REQ);
    assign in_rsp      = (state == RSP);
    // On a tie the cache that did not own the previous grant wins
    assign grant_dc    = dc_rd_req_valid && (!ic_rd_req_valid || !owner);
    assign rsp_hs      = mem_rd_rsp_valid && mem_rd_rsp_ready;
    assign cnt_at_last = (beat_cnt == LAST_CNT);

    // Arbitration FSM plus grant latch, beat counter and sticky burst error
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            addr_q   <= '0;
            beat_cnt <= '0;
            beat_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ic_rd_req_valid || dc_rd_req_valid) begin
                        owner    <= grant_dc;
                        addr_q   <= grant_dc ? dc_rd_req_addr : ic_rd_req_addr;
                        beat_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_rd_req_ready) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_hs) begin
                        beat_cnt <= cnt_at_last ? '0 : beat_cnt + 1'b1;
                        if (mem_rd_rsp_last != cnt_at_last) begin
                            beat_err <= 1'b1;
                        end
                        if (mem_rd_rsp_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign mem_rd_req_valid = in_req;
    assign mem_rd_req_addr  = in_req ? addr_q : '0;

    assign ic_rd_req_ready  = in_req && !owner && mem_rd_req_ready;
    assign dc_rd_req_ready  = in_req &&  owner && mem_rd_req_ready;

    assign ic_rd_rsp_valid  = in_rsp && !owner && mem_rd_rsp_valid;
    assign ic_rd_rsp_data   = (in_rsp && !owner) ? mem_rd_rsp_data : '0;
    assign ic_rd_rsp_last   = in_rsp && !owner && mem_rd_rsp_last;

    assign dc_rd_rsp_valid  = in_rsp &&  owner && mem_rd_rsp_valid;
    assign dc_rd_rsp_data   = (in_rsp && owner) ? mem_rd_rsp_data : '0;
    assign dc_rd_rsp_last   = in_rsp &&  owner && mem_rd_rsp_last;

    assign mem_rd_rsp_ready = in_rsp && (owner ? dc_rd_rsp_ready : ic_rd_rsp_ready);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: directed and randomized bursts against mem_rd_arbiter,
// with expected grants, routing and error flag derived from a small model.
module tb_mem_rd_arbiter;

    localparam int BL = 8;

    logic        clk;
    logic        rst;
    logic        ic_rd_req_valid;
    logic [31:0] ic_rd_req_addr;
    logic        ic_rd_req_ready;
    logic        ic_rd_rsp_valid;
    logic [31:0] ic_rd_rsp_data;
    logic        ic_rd_rsp_last;
    logic        ic_rd_rsp_ready;
    logic        dc_rd_req_valid;
    logic [31:0] dc_rd_req_addr;
    logic        dc_rd_req_ready;
    logic        dc_rd_rsp_valid;
    logic [31:0] dc_rd_rsp_data;
    logic        dc_rd_rsp_last;
    logic        dc_rd_rsp_ready;
    logic        mem_rd_req_valid;
    logic [31:0] mem_rd_req_addr;
    logic        mem_rd_req_ready;
    logic        mem_rd_rsp_valid;
    logic [31:0] mem_rd_rsp_data;
    logic        mem_rd_rsp_last;
    logic        mem_rd_rsp_ready;
    logic        owner;
    logic        busy;
    logic        beat_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: who held the last grant, and whether any burst so far
    // since reset had a length other than BL
    bit lastOwner = 1'b0;
    bit expErr    = 1'b0;

    mem_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .ic_rd_req_valid(ic_rd_req_valid), .ic_rd_req_addr(ic_rd_req_addr),
        .ic_rd_req_ready(ic_rd_req_ready), .ic_rd_rsp_valid(ic_rd_rsp_valid),
        .ic_rd_rsp_data(ic_rd_rsp_data), .ic_rd_rsp_last(ic_rd_rsp_last),
        .ic_rd_rsp_ready(ic_rd_rsp_ready),
        .dc_rd_req_valid(dc_rd_req_valid), .dc_rd_req_addr(dc_rd_req_addr),
        .dc_rd_req_ready(dc_rd_req_ready), .dc_rd_rsp_valid(dc_rd_rsp_valid),
        .dc_rd_rsp_data(dc_rd_rsp_data), .dc_rd_rsp_last(dc_rd_rsp_last),
        .dc_rd_rsp_ready(dc_rd_rsp_ready),
        .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_addr(mem_rd_req_addr),
        .mem_rd_req_ready(mem_rd_req_ready), .mem_rd_rsp_valid(mem_rd_rsp_valid),
        .mem_rd_rsp_data(mem_rd_rsp_data), .mem_rd_rsp_last(mem_rd_rsp_last),
        .mem_rd_rsp_ready(mem_rd_rsp_ready),
        .owner(owner), .busy(busy), .beat_err(beat_err)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_mem_req_valid"}, mem_rd_req_valid, 1'b0);
        check({tag, "_mem_rsp_ready"}, mem_rd_rsp_ready, 1'b0);
        check({tag, "_req_ready"}, {ic_rd_req_ready, dc_rd_req_ready}, 2'b00);
        check({tag, "_rsp_valid"}, {ic_rd_rsp_valid, dc_rd_rsp_valid}, 2'b00);
    endtask

    task automatic applyStimulus_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        lastOwner = 1'b0;
        expErr    = 1'b0;
    endtask

    // One full grant: arbitration, address phase with random memory stall,
    // then nBeats response beats. readyMode 0 = random cache ready,
    // 1 = toggling 1,0,1,0 with memory holding valid, 2 = always ready.
    // dataBase of 0 selects random beat data.
    task automatic applyStimulus_burst(input int nBeats, input bit withLast,
                                       input int readyMode, input logic [31:0] dataBase,
                                       input bit keepValid);
        bit          own;
        logic [31:0] a;
        bit          mv;
        bit          rdy;
        bit          toggle;
        bit          hs;
        logic [31:0] d;
        bit          lst;
        int          stall;

        own = (ic_rd_req_valid && dc_rd_req_valid) ? !lastOwner : dc_rd_req_valid;
        a   = own ? dc_rd_req_addr : ic_rd_req_addr;
        checkIdleOutputs("pre_grant");
        tick();
        lastOwner = own;
        check("grant_owner", owner, own);
        check("grant_busy", busy, 1'b1);
        check("grant_mem_req_valid", mem_rd_req_valid, 1'b1);
        check("grant_mem_req_addr", mem_rd_req_addr, a);

        stall = $urandom_range(0, 2);
        for (int s = 0; s < stall; s++) begin
            mem_rd_req_ready = 1'b0;
            #1;
            check("stall_req_ready", {ic_rd_req_ready, dc_rd_req_ready}, 2'b00);
            tick();
        end
        mem_rd_req_ready = 1'b1;
        #1;
        check("ic_req_ready", ic_rd_req_ready, !own);
        check("dc_req_ready", dc_rd_req_ready, own);
        check("req_addr_held", mem_rd_req_addr, a);
        tick();
        mem_rd_req_ready = 1'b0;
        if (!keepValid) begin
            if (own) dc_rd_req_valid = 1'b0;
            else     ic_rd_req_valid = 1'b0;
        end

        toggle = 1'b1;
        for (int i = 0; i < nBeats; i++) begin
            for (int att = 0; att < 40; att++) begin
                if (readyMode == 1) begin
                    mv     = 1'b1;
                    rdy    = toggle;
                    toggle = !toggle;
                end else begin
                    mv  = (att >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
                    rdy = (readyMode == 2 || att >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
                end
                d   = (dataBase != 0) ? dataBase + i : $urandom;
                lst = withLast && (i == nBeats - 1);
                mem_rd_rsp_valid = mv;
                mem_rd_rsp_data  = d;
                mem_rd_rsp_last  = lst;
                if (own) begin
                    dc_rd_rsp_ready = rdy;
                    ic_rd_rsp_ready = $urandom_range(0, 1);
                end else begin
                    ic_rd_rsp_ready = rdy;
                    dc_rd_rsp_ready = $urandom_range(0, 1);
                end
                #1;
                check("mem_rsp_ready", mem_rd_rsp_ready, rdy);
                if (own) begin
                    check("dc_rsp_valid", dc_rd_rsp_valid, mv);
                    check("dc_rsp_data", dc_rd_rsp_data, d);
                    check("dc_rsp_last", dc_rd_rsp_last, lst);
                    check("ic_rsp_quiet", {ic_rd_rsp_valid, ic_rd_rsp_last, ic_rd_rsp_data}, 34'h0);
                end else begin
                    check("ic_rsp_valid", ic_rd_rsp_valid, mv);
                    check("ic_rsp_data", ic_rd_rsp_data, d);
                    check("ic_rsp_last", ic_rd_rsp_last, lst);
                    check("dc_rsp_quiet", {dc_rd_rsp_valid, dc_rd_rsp_last, dc_rd_rsp_data}, 34'h0);
                end
                hs = mv && rdy;
                tick();
                if (hs) break;
            end
        end
        mem_rd_rsp_valid = 1'b0;
        mem_rd_rsp_last  = 1'b0;
        mem_rd_rsp_data  = '0;
        ic_rd_rsp_ready  = 1'b0;
        dc_rd_rsp_ready  = 1'b0;

        if (withLast) begin
            if (nBeats != BL) expErr = 1'b1;
            checkIdleOutputs("post_burst");
            check("post_owner", owner, own);
            check("post_beat_err", beat_err, expErr);
        end
    endtask

    task automatic checkOutput_reset(input string tag);
        checkIdleOutputs(tag);
        check({tag, "_owner"}, owner, 1'b0);
        check({tag, "_beat_err"}, beat_err, 1'b0);
        check({tag, "_mem_req_addr"}, mem_rd_req_addr, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        ic_rd_req_valid = 0; ic_rd_req_addr = 0; ic_rd_rsp_ready = 0;
        dc_rd_req_valid = 0; dc_rd_req_addr = 0; dc_rd_rsp_ready = 0;
        mem_rd_req_ready = 0; mem_rd_rsp_valid = 0; mem_rd_rsp_data = 0; mem_rd_rsp_last = 0;
        tick();
        applyStimulus_reset();
        checkOutput_reset("reset");

        // Single I-cache miss with known beat data
        ic_rd_req_addr  = 32'h0000_1020;
        ic_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 2, 32'h11, 1'b0);

        // Simultaneous requests right after reset: D-cache first
        applyStimulus_reset();
        ic_rd_req_addr = 32'h100; dc_rd_req_addr = 32'h200;
        ic_rd_req_valid = 1'b1; dc_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);
        check("tie_first_dc", lastOwner, 1'b1);
        applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);
        check("tie_second_ic", lastOwner, 1'b0);

        // Sustained load: grants alternate
        ic_rd_req_valid = 1'b1; dc_rd_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b1);
            check("fair_alternate", owner, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        ic_rd_req_valid = 1'b0; dc_rd_req_valid = 1'b0;

        // Backpressure with toggling owner ready, both owners
        dc_rd_req_addr = 32'h0000_4440; dc_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 1, 32'hA0, 1'b0);
        ic_rd_req_addr = 32'h0000_8880; ic_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 1, 32'hB0, 1'b0);

        // Randomized traffic with well-formed bursts
        for (int k = 0; k < 16; k++) begin
            int pick;
            pick = $urandom_range(1, 3);
            ic_rd_req_valid = pick[0];
            dc_rd_req_valid = pick[1];
            ic_rd_req_addr  = $urandom & 32'hFFFF_FFE0;
            dc_rd_req_addr  = $urandom & 32'hFFFF_FFE0;
            applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);
            ic_rd_req_valid = 1'b0; dc_rd_req_valid = 1'b0;
        end

        // Short burst sets the sticky error, good bursts keep it set
        ic_rd_req_addr = 32'h0000_0040; ic_rd_req_valid = 1'b1;
        applyStimulus_burst(5, 1'b1, 2, 32'h0, 1'b0);
        dc_rd_req_addr = 32'h0000_0060; dc_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);
        ic_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);

        // Reset clears the error; an over-long burst sets it again
        applyStimulus_reset();
        checkOutput_reset("err_reset");
        dc_rd_req_addr = 32'h0000_0080; dc_rd_req_valid = 1'b1;
        applyStimulus_burst(BL + 1, 1'b1, 2, 32'h0, 1'b0);

        // Reset in the middle of a burst after three beats
        applyStimulus_reset();
        dc_rd_req_addr = 32'h0000_00A0; dc_rd_req_valid = 1'b1;
        applyStimulus_burst(3, 1'b0, 2, 32'h0, 1'b0);
        check("mid_busy_before", busy, 1'b1);
        mem_rd_rsp_valid = 1'b1;
        dc_rd_rsp_ready  = 1'b1;
        applyStimulus_reset();
        #1;
        checkOutput_reset("mid_reset");
        mem_rd_rsp_valid = 1'b0;
        dc_rd_rsp_ready  = 1'b0;

        // Arbiter is usable again after the mid-burst reset
        ic_rd_req_addr = 32'h0000_0C00; ic_rd_req_valid = 1'b1;
        applyStimulus_burst(BL, 1'b1, 0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
